shading_pixel_writer: RTL and testbench
=======================================

SHADING_PIXEL_WRITER -- requirements
Module: shading_pixel_writer

Interface
REQ-001 SHALL have parameter FB_WIDTH, default 640, pixels per row.
REQ-002 SHALL have parameter FB_HEIGHT, default 480, rows per frame.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of pixel 0.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, pixel buffer entries (power of 2, >=2).
REQ-005 SHALL have port i_clk  input  1  sole clock, rising edge; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port i_rstn  input  1  asynchronous active-low reset.
REQ-007 SHALL have port i_start  input  1  one-cycle pulse, begin frame.
REQ-008 SHALL have port i_valid  input  1  shaded pixel present.
REQ-009 SHALL have port i_light  input  3x32 signed  RGB, Q16.16 fixed point, [0]=R.
REQ-010 SHALL have port o_ready  output  1  pixel accepted when i_valid&&o_ready.
REQ-011 SHALL have port o_wr_valid  output  1  write request valid.
REQ-012 SHALL have port o_wr_addr  output  32  byte address.
REQ-013 SHALL have port o_wr_data  output  32  packed pixel 0x00RRGGBB.
REQ-014 SHALL have port i_wr_ready  input  1  write accepted when o_wr_valid&&i_wr_ready.
REQ-015 SHALL have port o_busy  output  1  high in any state except IDLE.
REQ-016 SHALL have port o_frame_done  output  1  one-cycle pulse after last write accepted.

Function
REQ-017 SHALL implement FSM IDLE -> RUN on i_start; RUN -> DONE on acceptance of write FB_WIDTH*FB_HEIGHT-1; DONE -> IDLE unconditionally after one cycle.
REQ-018 SHALL ignore i_start outside IDLE.
REQ-019 SHALL drive o_ready = (state==RUN) && FIFO not full && pixels accepted < FB_WIDTH*FB_HEIGHT; o_ready SHALL NOT depend combinationally on i_wr_ready.
REQ-020 SHALL convert each channel: negative (bit31=1) -> 8'h00; value >= 32'sh0001_0000 -> 8'hFF; else bits [15:8] (truncate).
REQ-021 SHALL push the converted 24-bit pixel into the FIFO in the acceptance cycle; earliest o_wr_valid is the next cycle (latency 1).
REQ-022 SHALL hold o_wr_valid, o_wr_addr, o_wr_data stable until accepted.
REQ-023 SHALL set o_wr_addr = BASE_ADDR + 4*write_index; write_index increments per accepted write and resets to 0 on i_start.
REQ-024 SHALL handle FIFO push and pop in the same cycle (including when full-then-popped) with count unchanged and no data loss; o_ready is still low that cycle when full.
REQ-025 SHALL pulse o_frame_done for exactly the DONE cycle.
REQ-026 SHALL drop no pixel and duplicate no write under arbitrary i_valid/i_wr_ready stalls.

Reset
REQ-027 SHALL on i_rstn low, at any time including mid-frame, asynchronously force state IDLE, FIFO empty, counters 0, o_ready=0, o_wr_valid=0, o_wr_addr=BASE_ADDR, o_wr_data=0, o_busy=0, o_frame_done=0.
REQ-028 SHALL require i_start after reset release before accepting pixels.

Structure
REQ-029 SHALL place FIP_ONE (32'sh0001_0000), the state enum, and the channel-clamp function in shared package shading_pkg.
REQ-030 SHALL instantiate one sub-module, sync_fifo (parameterized width 24, depth FIFO_DEPTH, full/empty/count outputs).

Verification
REQ-031 Clamp: i_light={32'sh0000_8000, 32'shFFFF_0000, 32'sh0001_2000}, i_wr_ready=1 -> o_wr_data=32'h0080_00FF at addr BASE_ADDR, one cycle after acceptance.
REQ-032 Full frame FB_WIDTH=4, FB_HEIGHT=2, no stalls -> 8 writes, addresses 0x00..0x1C, o_frame_done single pulse, o_ready=0 after 8th pixel.
REQ-033 Backpressure: i_wr_ready=0 for 10 cycles while streaming -> exactly FIFO_DEPTH pixels accepted, o_wr_valid/addr/data stable; release -> in-order drain.
REQ-034 Simultaneous: FIFO full, i_valid=1, i_wr_ready=1 -> one write out, no push that cycle, push next cycle, count correct.
REQ-035 Mid-frame reset after 3 of 8 writes -> all outputs at reset values; new i_start restarts at BASE_ADDR.
REQ-036 i_start pulsed during RUN -> ignored; addresses continue unbroken.

Source files
------------

// File: rtl/shading_pkg.sv
// Shared types and helpers for the shading pixel writer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package shading_pkg;

    localparam logic signed [31:0] FIP_ONE = 32'sh0001_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Q16.16 light to 8-bit channel: negatives floor to 0, >= 1.0 saturates.
    function automatic logic [7:0] clamp_ch(input logic signed [31:0] v);
        logic [7:0] res;
        if (v[31])
            res = 8'h00;
        else if (v >= FIP_ONE)
            res = 8'hFF;
        else
            res = v[15:8];
        return res;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock ring-buffer FIFO with occupancy count.
// Latency: pushed word visible at dout the cycle after the push.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + AW'(1);
            if (do_pop)
                rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/shading_pixel_writer.sv
// Clamps shaded Q16.16 RGB pixels to 0x00RRGGBB and writes a frame to linear memory.
// Latency: one cycle from pixel acceptance to the earliest write request.
// Backpressure: o_ready drops when the pixel buffer is full; writes hold until i_wr_ready.
module shading_pixel_writer
    import shading_pkg::*;
#(
    parameter int          FB_WIDTH   = 640,
    parameter int          FB_HEIGHT  = 480,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_start,
    input  logic             i_valid,
    input  logic [2:0][31:0] i_light,
    output logic             o_ready,
    output logic             o_wr_valid,
    output logic [31:0]      o_wr_addr,
    output logic [31:0]      o_wr_data,
    input  logic             i_wr_ready,
    output logic             o_busy,
    output logic             o_frame_done
);
    localparam int TOTAL = FB_WIDTH * FB_HEIGHT;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int FCW   = $clog2(FIFO_DEPTH + 1);

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   pix_cnt;
    logic [CW-1:0]   wr_idx;
    logic [23:0]     pixel;
    logic [23:0]     fifo_dout;
    logic            fifo_full;
    logic            fifo_empty;
    logic [FCW-1:0]  fifo_cnt;
    logic            accept;
    logic            wr_fire;
    logic            last_wr;
    logic            start_evt;
    logic            unused_fifo_cnt;

    assign pixel     = {clamp_ch(i_light[0]), clamp_ch(i_light[1]), clamp_ch(i_light[2])};
    assign accept    = i_valid && o_ready;
    assign wr_fire   = o_wr_valid && i_wr_ready;
    assign last_wr   = wr_fire && (wr_idx == CW'(TOTAL - 1));
    assign start_evt = (state == IDLE) && i_start;
    assign unused_fifo_cnt = &{1'b0, fifo_cnt};

    sync_fifo #(
        .WIDTH (24),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rstn),
        .push  (accept),
        .din   (pixel),
        .pop   (wr_fire),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = RUN;
            RUN:     if (last_wr) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_busy       = (state != IDLE);
        o_frame_done = (state == DONE);
        o_ready      = (state == RUN) && !fifo_full && (pix_cnt < CW'(TOTAL));
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            pix_cnt <= '0;
            wr_idx  <= '0;
        end else if (start_evt) begin
            pix_cnt <= '0;
            wr_idx  <= '0;
        end else begin
            if (accept)
                pix_cnt <= pix_cnt + CW'(1);
            if (wr_fire)
                wr_idx <= wr_idx + CW'(1);
        end
    end

    // The FIFO head and write index only move on acceptance, so the request holds while stalled.
    assign o_wr_valid = !fifo_empty;
    assign o_wr_addr  = BASE_ADDR + (32'(wr_idx) << 2);
    assign o_wr_data  = fifo_empty ? 32'h0 : {8'h00, fifo_dout};

endmodule

// File: tb/tb_shading_pixel_writer.sv
// Directed bench for shading_pixel_writer on a 4x2 frame with a 4-entry buffer.
module tb_shading_pixel_writer;

    logic             clk = 1'b0;
    logic             rstn = 1'b1;
    logic             start = 1'b0;
    logic             valid = 1'b0;
    logic             wr_ready = 1'b0;
    logic [2:0][31:0] light = '0;
    logic             ready;
    logic             wr_valid;
    logic [31:0]      wr_addr;
    logic [31:0]      wr_data;
    logic             busy;
    logic             frame_done;

    int total = 0;
    int bad = 0;
    int sent = 0;
    int acc_cnt = 0;
    int done_cnt = 0;
    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];

    always #5 clk = ~clk;

    shading_pixel_writer #(
        .FB_WIDTH   (4),
        .FB_HEIGHT  (2),
        .BASE_ADDR  (32'h0000_0000),
        .FIFO_DEPTH (4)
    ) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_start      (start),
        .i_valid      (valid),
        .i_light      (light),
        .o_ready      (ready),
        .o_wr_valid   (wr_valid),
        .o_wr_addr    (wr_addr),
        .o_wr_data    (wr_data),
        .i_wr_ready   (wr_ready),
        .o_busy       (busy),
        .o_frame_done (frame_done)
    );

    always @(posedge clk) begin
        if (rstn) begin
            if (valid && ready)
                acc_cnt++;
            if (wr_valid && wr_ready) begin
                wq_addr.push_back(wr_addr);
                wq_data.push_back(wr_data);
            end
            if (frame_done)
                done_cnt++;
        end
    end

    // Pixel k: R = 16k+3 (truncated), G exactly 1.0 (saturates), B 0x7F80 (truncates to 0x7F).
    function automatic logic [2:0][31:0] mk(input int k);
        logic [2:0][31:0] m;
        m[0] = 32'((k * 16 + 3) << 8);
        m[1] = 32'h0001_0000;
        m[2] = 32'h0000_7F80;
        return m;
    endfunction

    function automatic logic [31:0] exp_data(input int k);
        logic [7:0] r;
        r = 8'(k * 16 + 3);
        return {8'h00, r, 8'hFF, 8'h7F};
    endfunction

    task automatic clear_log();
        wq_addr.delete();
        wq_data.delete();
        acc_cnt = 0;
        done_cnt = 0;
        sent = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rstn = 1'b0;
        start = 1'b0;
        valid = 1'b0;
        wr_ready = 1'b0;
        light = '0;
        @(negedge clk);
        rstn = 1'b1;
        clear_log();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input int n, input int budget);
        for (int c = 0; c < budget && sent < n; c++) begin
            @(negedge clk);
            valid = 1'b1;
            light = mk(sent);
            #1;
            if (ready)
                sent++;
        end
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int c = 0; c < budget && done_cnt == 0; c++)
            @(negedge clk);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rstn = 1'b0;
        #3;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b expected 0", ready); end
        total++; if (wr_valid !== 1'b0) begin bad++; $display("FAIL rst_wr_valid: got %b expected 0", wr_valid); end
        total++; if (wr_addr !== 32'h0) begin bad++; $display("FAIL rst_wr_addr: got %h expected 00000000", wr_addr); end
        total++; if (wr_data !== 32'h0) begin bad++; $display("FAIL rst_wr_data: got %h expected 00000000", wr_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_frame_done: got %b expected 0", frame_done); end
        @(negedge clk);
        rstn = 1'b1;
        clear_log();
        valid = 1'b1;
        light = mk(0);
        wr_ready = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        total++; if (acc_cnt !== 0) begin bad++; $display("FAIL no_start_accept: got %0d expected 0", acc_cnt); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL no_start_ready: got %b expected 0", ready); end
        valid = 1'b0;
    endtask

    task automatic test_clamp();
        apply_reset();
        pulse_start();
        @(negedge clk);
        valid = 1'b1;
        light[0] = 32'h0000_8000;
        light[1] = 32'hFFFF_0000;
        light[2] = 32'h0001_2000;
        wr_ready = 1'b1;
        #1;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL clamp_ready: got %b expected 1", ready); end
        @(negedge clk);
        valid = 1'b0;
        #1;
        total++; if (wr_valid !== 1'b1) begin bad++; $display("FAIL clamp_wr_valid: got %b expected 1", wr_valid); end
        total++; if (wr_addr !== 32'h0) begin bad++; $display("FAIL clamp_addr: got %h expected 00000000", wr_addr); end
        total++; if (wr_data !== 32'h0080_00FF) begin bad++; $display("FAIL clamp_data: got %h expected 008000ff", wr_data); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL clamp_busy: got %b expected 1", busy); end
    endtask

    task automatic test_full_frame();
        apply_reset();
        wr_ready = 1'b1;
        pulse_start();
        feed(8, 40);
        #1;
        total++; if (sent !== 8) begin bad++; $display("FAIL ff_sent: got %0d expected 8", sent); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL ff_ready_after_last: got %b expected 0", ready); end
        wait_done(20);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (i >= wq_addr.size() || wq_addr[i] !== 32'(i * 4) || wq_data[i] !== exp_data(i)) begin
                bad++;
                $display("FAIL ff_write%0d: got addr %h data %h expected addr %h data %h", i,
                         (i < wq_addr.size()) ? wq_addr[i] : 32'hx, (i < wq_data.size()) ? wq_data[i] : 32'hx,
                         32'(i * 4), exp_data(i));
            end
        end
        total++; if (wq_addr.size() !== 8) begin bad++; $display("FAIL ff_write_count: got %0d expected 8", wq_addr.size()); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL ff_done_pulses: got %0d expected 1", done_cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ff_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        wr_ready = 1'b0;
        pulse_start();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            valid = 1'b1;
            light = mk(sent);
            #1;
            if (c >= 1) begin
                total++;
                if (wr_valid !== 1'b1 || wr_addr !== 32'h0 || wr_data !== exp_data(0)) begin
                    bad++;
                    $display("FAIL bp_hold_c%0d: got v=%b addr %h data %h expected v=1 addr 00000000 data %h",
                             c, wr_valid, wr_addr, wr_data, exp_data(0));
                end
            end
            if (ready)
                sent++;
        end
        total++; if (sent !== 4) begin bad++; $display("FAIL bp_accepted: got %0d expected 4", sent); end
        wr_ready = 1'b1;
        feed(8, 40);
        wait_done(20);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (i >= wq_addr.size() || wq_addr[i] !== 32'(i * 4) || wq_data[i] !== exp_data(i)) begin
                bad++;
                $display("FAIL bp_drain%0d: got addr %h data %h expected addr %h data %h", i,
                         (i < wq_addr.size()) ? wq_addr[i] : 32'hx, (i < wq_data.size()) ? wq_data[i] : 32'hx,
                         32'(i * 4), exp_data(i));
            end
        end
        total++; if (wq_addr.size() !== 8) begin bad++; $display("FAIL bp_write_count: got %0d expected 8", wq_addr.size()); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL bp_done_pulses: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        wr_ready = 1'b0;
        pulse_start();
        feed(4, 10);
        @(negedge clk);
        valid = 1'b1;
        light = mk(4);
        wr_ready = 1'b1;
        #1;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL sim_ready_full: got %b expected 0", ready); end
        @(negedge clk);
        wr_ready = 1'b0;
        #1;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL sim_ready_after_pop: got %b expected 1", ready); end
        total++;
        if (wr_addr !== 32'h4 || wr_data !== exp_data(1)) begin
            bad++;
            $display("FAIL sim_head: got addr %h data %h expected addr 00000004 data %h", wr_addr, wr_data, exp_data(1));
        end
        if (ready)
            sent++;
        @(negedge clk);
        valid = 1'b0;
        #1;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL sim_full_again: got %b expected 0", ready); end
        total++; if (acc_cnt !== 5) begin bad++; $display("FAIL sim_accepted: got %0d expected 5", acc_cnt); end
        wr_ready = 1'b1;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (i >= wq_addr.size() || wq_addr[i] !== 32'(i * 4) || wq_data[i] !== exp_data(i)) begin
                bad++;
                $display("FAIL sim_order%0d: got addr %h data %h expected addr %h data %h", i,
                         (i < wq_addr.size()) ? wq_addr[i] : 32'hx, (i < wq_data.size()) ? wq_data[i] : 32'hx,
                         32'(i * 4), exp_data(i));
            end
        end
        total++; if (wq_addr.size() !== 5) begin bad++; $display("FAIL sim_write_count: got %0d expected 5", wq_addr.size()); end
    endtask

    task automatic test_midframe_reset();
        apply_reset();
        wr_ready = 1'b1;
        pulse_start();
        feed(4, 20);
        total++; if (wq_addr.size() !== 3) begin bad++; $display("FAIL mr_writes_before: got %0d expected 3", wq_addr.size()); end
        total++; if (wr_valid !== 1'b1) begin bad++; $display("FAIL mr_pending: got %b expected 1", wr_valid); end
        #2 rstn = 1'b0;
        #1;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL mr_ready: got %b expected 0", ready); end
        total++; if (wr_valid !== 1'b0) begin bad++; $display("FAIL mr_wr_valid: got %b expected 0", wr_valid); end
        total++; if (wr_addr !== 32'h0) begin bad++; $display("FAIL mr_wr_addr: got %h expected 00000000", wr_addr); end
        total++; if (wr_data !== 32'h0) begin bad++; $display("FAIL mr_wr_data: got %h expected 00000000", wr_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mr_busy: got %b expected 0", busy); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL mr_frame_done: got %b expected 0", frame_done); end
        @(negedge clk);
        rstn = 1'b1;
        clear_log();
        valid = 1'b1;
        light = mk(0);
        repeat (3) @(negedge clk);
        total++; if (acc_cnt !== 0) begin bad++; $display("FAIL mr_no_start_accept: got %0d expected 0", acc_cnt); end
        valid = 1'b0;
        pulse_start();
        feed(8, 40);
        wait_done(20);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (i >= wq_addr.size() || wq_addr[i] !== 32'(i * 4) || wq_data[i] !== exp_data(i)) begin
                bad++;
                $display("FAIL mr_restart%0d: got addr %h data %h expected addr %h data %h", i,
                         (i < wq_addr.size()) ? wq_addr[i] : 32'hx, (i < wq_data.size()) ? wq_data[i] : 32'hx,
                         32'(i * 4), exp_data(i));
            end
        end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL mr_done_pulses: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_start_ignored();
        apply_reset();
        wr_ready = 1'b1;
        pulse_start();
        feed(3, 20);
        @(negedge clk);
        start = 1'b1;
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL si_busy: got %b expected 1", busy); end
        @(negedge clk);
        start = 1'b0;
        feed(8, 40);
        wait_done(20);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (i >= wq_addr.size() || wq_addr[i] !== 32'(i * 4) || wq_data[i] !== exp_data(i)) begin
                bad++;
                $display("FAIL si_write%0d: got addr %h data %h expected addr %h data %h", i,
                         (i < wq_addr.size()) ? wq_addr[i] : 32'hx, (i < wq_data.size()) ? wq_data[i] : 32'hx,
                         32'(i * 4), exp_data(i));
            end
        end
        total++; if (wq_addr.size() !== 8) begin bad++; $display("FAIL si_write_count: got %0d expected 8", wq_addr.size()); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL si_done_pulses: got %0d expected 1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_clamp();
        test_full_frame();
        test_backpressure();
        test_simultaneous();
        test_midframe_reset();
        test_start_ignored();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
